// File: rtl/prbs_pkg.sv
// ----------------------------------------------------------------------------
// prbs_pkg
//   Shared definitions for the PRBS generator/checker block.
//   - state_t       : lock FSM encoding (ST_UNLOCK, ST_LOCK)
//   - default_taps  : recommended Fibonacci feedback mask for common widths
//   - cnt_width     : width of a counter that must hold max(a, b)
//   No ports (package).
// ----------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic {
        ST_UNLOCK = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    // Maximal-length masks for the widths the link actually uses; other
    // widths fall back to the 8-bit mask and must override TAPS explicitly.
    function automatic logic [31:0] default_taps(input int unsigned w);
        case (w)
            8:       default_taps = 32'h0000_00B8;
            16:      default_taps = 32'h0000_D008;
            32:      default_taps = 32'h8020_0003;
            default: default_taps = 32'h0000_00B8;
        endcase
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b);
        cnt_width = $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/prbs_gen_check_if.sv
// ----------------------------------------------------------------------------
// prbs_gen_check_if
//   Bundles the data-side signals of prbs_gen_check.
//   master : drives i_valid, i_seed, i_inject, i_inj_mask; reads the outputs
//   slave  : the prbs_gen_check block itself
//   Signals:
//     i_valid    1      advance generator / checker consumes current word
//     i_seed     WIDTH  seed sampled on soft_rst
//     i_inject   1      XOR i_inj_mask into o_data
//     i_inj_mask WIDTH  error injection mask
//     o_data     WIDTH  generator word after injection
//     o_lock     1      checker locked
//     o_match    1      last consumed word matched prediction
//     o_err_cnt  ERR_W  saturating mismatch count while locked
//     o_state    1      lock FSM state (debug visibility)
//
// Handshake: i_valid is a pure qualifier with no ready. The block accepts
// every cycle, so a word is transferred on each rising edge where i_valid
// is high, and nothing changes (except o_match clearing) when it is low.
// ----------------------------------------------------------------------------
interface prbs_gen_check_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
);
    import prbs_pkg::*;

    logic             i_valid;
    logic [WIDTH-1:0] i_seed;
    logic             i_inject;
    logic [WIDTH-1:0] i_inj_mask;
    logic [WIDTH-1:0] o_data;
    logic             o_lock;
    logic             o_match;
    logic [ERR_W-1:0] o_err_cnt;
    state_t           o_state;

    modport master (
        output i_valid, i_seed, i_inject, i_inj_mask,
        input  o_data, o_lock, o_match, o_err_cnt, o_state
    );

    modport slave (
        input  i_valid, i_seed, i_inject, i_inj_mask,
        output o_data, o_lock, o_match, o_err_cnt, o_state
    );

endinterface

// File: rtl/prbs_lfsr_next.sv
// ----------------------------------------------------------------------------
// prbs_lfsr_next
//   Combinational one-step advance of a Fibonacci LFSR:
//     next = {q[WIDTH-2:0], ^(q & TAPS)}
//   Ports:
//     q_i     WIDTH  current LFSR value
//     next_o  WIDTH  value after one shift
// ----------------------------------------------------------------------------
module prbs_lfsr_next
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = {q_i[WIDTH-2:0], ^(q_i & TAPS)};

endmodule

// File: rtl/prbs_gen_check.sv
// ----------------------------------------------------------------------------
// prbs_gen_check
//   Link self-test block: PRBS generator plus a self-synchronising checker
//   with error injection, a lock/unlock FSM and flywheel tracking once
//   locked.
//   Ports:
//     clk       1   rising-edge clock
//     rst       1   synchronous active-high full reset (wins over soft_rst)
//     soft_rst  1   synchronous active-high restart from bus.i_seed
//     bus       prbs_gen_check_if.slave (see interface file)
//   Build option:
//     PRBS_ERR_CNT_EN  defined  -> saturating mismatch counter on o_err_cnt
//                      undefined-> no counter logic, o_err_cnt tied to 0
// ----------------------------------------------------------------------------
module prbs_gen_check
    import prbs_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
    parameter int               LOCK_CNT     = 4,
    parameter int               UNLOCK_CNT   = 3,
    parameter int               ERR_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    prbs_gen_check_if.slave   bus
);

    localparam int CW = cnt_width(LOCK_CNT, UNLOCK_CNT);
    localparam logic [CW-1:0] LOCK_TH   = CW'(LOCK_CNT);
    localparam logic [CW-1:0] UNLOCK_TH = CW'(UNLOCK_CNT);

    logic [WIDTH-1:0] gen_q, gen_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic             have_ref_q, have_ref_d;
    logic [CW-1:0]    mcnt_q, mcnt_d;
    logic [CW-1:0]    xcnt_q, xcnt_d;
    logic             match_q, match_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] gen_nxt;
    logic [WIDTH-1:0] chk_pred;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] seed_sel;
    logic [CW-1:0]    mcnt_inc;
    logic [CW-1:0]    xcnt_inc;
    logic             hit;
    logic             cmp_en;
    logic             step_hit;
    logic             step_miss;

    // Generator advance and checker prediction share the same polynomial.
    prbs_lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_gen_next (
        .q_i    (gen_q),
        .next_o (gen_nxt)
    );

    prbs_lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_chk_next (
        .q_i    (chk_q),
        .next_o (chk_pred)
    );

    assign data     = gen_q ^ (bus.i_inject ? bus.i_inj_mask : '0);
    assign seed_sel = (bus.i_seed == '0) ? DEFAULT_SEED : bus.i_seed;
    assign hit      = (data == chk_pred);
    assign mcnt_inc = mcnt_q + CW'(1);
    assign xcnt_inc = xcnt_q + CW'(1);

    // A word is only judged once the checker holds a reference; the first
    // word after reset or unlock merely seeds it.
    assign cmp_en    = bus.i_valid && ((state_q == ST_LOCK) || have_ref_q);
    assign step_hit  = cmp_en && hit;
    assign step_miss = cmp_en && !hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state_q <= ST_UNLOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCK: begin
                if (step_hit && (mcnt_inc == LOCK_TH)) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (step_miss && (xcnt_inc == UNLOCK_TH)) begin
                    state_d = ST_UNLOCK;
                end
            end
            default: state_d = ST_UNLOCK;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        gen_d      = gen_q;
        chk_d      = chk_q;
        have_ref_d = have_ref_q;
        mcnt_d     = mcnt_q;
        xcnt_d     = xcnt_q;
        match_d    = 1'b0;
        if (bus.i_valid) begin
            gen_d   = gen_nxt;
            match_d = step_hit;
            case (state_q)
                ST_UNLOCK: begin
                    // Received data reseeds the checker until lock.
                    chk_d      = data;
                    have_ref_d = 1'b1;
                    if (step_hit) begin
                        mcnt_d = mcnt_inc;
                    end else if (step_miss) begin
                        mcnt_d = '0;
                    end
                    if (state_d == ST_LOCK) begin
                        mcnt_d = '0;
                        xcnt_d = '0;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: free-run on the prediction so a corrupted
                    // word cannot knock the checker off the sequence.
                    chk_d = chk_pred;
                    if (step_hit) begin
                        xcnt_d = '0;
                    end else begin
                        xcnt_d = xcnt_inc;
                    end
                    if (state_d == ST_UNLOCK) begin
                        have_ref_d = 1'b0;
                        mcnt_d     = '0;
                        xcnt_d     = '0;
                    end
                end
                default: begin
                    have_ref_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q      <= DEFAULT_SEED;
            chk_q      <= '0;
            have_ref_q <= 1'b0;
            mcnt_q     <= '0;
            xcnt_q     <= '0;
            match_q    <= 1'b0;
        end else if (soft_rst) begin
            gen_q      <= seed_sel;
            chk_q      <= '0;
            have_ref_q <= 1'b0;
            mcnt_q     <= '0;
            xcnt_q     <= '0;
            match_q    <= 1'b0;
        end else begin
            gen_q      <= gen_d;
            chk_q      <= chk_d;
            have_ref_q <= have_ref_d;
            mcnt_q     <= mcnt_d;
            xcnt_q     <= xcnt_d;
            match_q    <= match_d;
        end
    end

    assign bus.o_data  = data;
    assign bus.o_lock  = (state_q == ST_LOCK);
    assign bus.o_match = match_q;
    assign bus.o_state = state_q;

`ifdef PRBS_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_inc;

    // Only mismatches seen while locked are link errors; acquisition noise
    // is ignored. Unlock does not clear the count.
    assign err_inc = step_miss && (state_q == ST_LOCK);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_err_cnt = err_cnt_q;
`else
    assign bus.o_err_cnt = ERR_W'(0);
`endif

endmodule

// File: tb/tb_prbs_gen_check.sv
// ----------------------------------------------------------------------------
// tb_prbs_gen_check
//   Directed bench for prbs_gen_check at default parameters. Expected
//   values for o_err_cnt follow the PRBS_ERR_CNT_EN build option.
// ----------------------------------------------------------------------------
module tb_prbs_gen_check;
    import prbs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic soft_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prbs_gen_check_if #(.WIDTH(8), .ERR_W(16)) bus ();

    prbs_gen_check dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .bus      (bus)
    );

`ifdef PRBS_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int        checks   = 0;
    int        failures = 0;
    logic [7:0] exp_gen;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        nxt = {x[6:0], ^(x & 8'hB8)};
    endfunction

    function automatic logic [31:0] e(input logic [31:0] n);
        e = ERR_EN ? n : 32'd0;
    endfunction

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One valid cycle: check o_data before the edge, then the registered
    // outputs just after it.
    task automatic vstep(input string tag, input logic inj,
                         input logic exp_match, input logic exp_lock,
                         input logic [31:0] exp_err);
        bus.i_valid  = 1'b1;
        bus.i_inject = inj;
        #1;
        chk({tag, "_data"}, {24'd0, bus.o_data}, {24'd0, exp_gen ^ (inj ? 8'h01 : 8'h00)});
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_inject = 1'b0;
        exp_gen      = nxt(exp_gen);
        chk({tag, "_match"}, {31'd0, bus.o_match}, {31'd0, exp_match});
        chk({tag, "_lock"},  {31'd0, bus.o_lock},  {31'd0, exp_lock});
        chk({tag, "_err"},   {16'd0, bus.o_err_cnt}, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  seq1 [6];
        logic [31:0] sat;
        seq1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

        rst            = 1'b1;
        soft_rst       = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_seed     = 8'h00;
        bus.i_inject   = 1'b0;
        bus.i_inj_mask = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_data",  {24'd0, bus.o_data}, 32'h01);
        chk("rst_lock",  {31'd0, bus.o_lock}, 32'd0);
        chk("rst_match", {31'd0, bus.o_match}, 32'd0);
        chk("rst_err",   {16'd0, bus.o_err_cnt}, 32'd0);
        chk("rst_state", {31'd0, bus.o_state}, {31'd0, ST_UNLOCK});

        // Test 1: 6 clean valids, hand-computed sequence, lock on 5th edge
        for (int i = 0; i < 6; i++) begin
            chk("t1_data", {24'd0, bus.o_data}, {24'd0, seq1[i]});
            bus.i_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            chk("t1_match", {31'd0, bus.o_match}, (i >= 1) ? 32'd1 : 32'd0);
            chk("t1_lock",  {31'd0, bus.o_lock},  (i >= 4) ? 32'd1 : 32'd0);
        end
        chk("t1_data7", {24'd0, bus.o_data}, 32'h47);
        chk("t1_state", {31'd0, bus.o_state}, {31'd0, ST_LOCK});
        exp_gen = 8'h47;

        // Idle cycle: nothing moves except o_match clearing
        @(posedge clk);
        #1;
        chk("idle_match", {31'd0, bus.o_match}, 32'd0);
        chk("idle_lock",  {31'd0, bus.o_lock}, 32'd1);
        chk("idle_data",  {24'd0, bus.o_data}, 32'h47);

        // Test 2: two isolated injected errors while locked
        vstep("t2a", 1'b1, 1'b0, 1'b1, e(1));
        vstep("t2b", 1'b0, 1'b1, 1'b1, e(1));
        vstep("t2c", 1'b1, 1'b0, 1'b1, e(2));
        vstep("t2d", 1'b0, 1'b1, 1'b1, e(2));

        // Test 3: three consecutive errors drop lock; 5 clean valids relock
        vstep("t3a", 1'b1, 1'b0, 1'b1, e(3));
        vstep("t3b", 1'b1, 1'b0, 1'b1, e(4));
        vstep("t3c", 1'b1, 1'b0, 1'b0, e(5));
        vstep("t3d", 1'b0, 1'b0, 1'b0, e(5));
        vstep("t3e", 1'b0, 1'b1, 1'b0, e(5));
        vstep("t3f", 1'b0, 1'b1, 1'b0, e(5));
        vstep("t3g", 1'b0, 1'b1, 1'b0, e(5));
        vstep("t3h", 1'b0, 1'b1, 1'b1, e(5));

        // Test 4: soft_rst with zero seed falls back to default, then A5
        soft_rst   = 1'b1;
        bus.i_seed = 8'h00;
        @(posedge clk);
        #1;
        soft_rst = 1'b0;
        chk("t4_data0", {24'd0, bus.o_data}, 32'h01);
        chk("t4_lock",  {31'd0, bus.o_lock}, 32'd0);
        chk("t4_err",   {16'd0, bus.o_err_cnt}, 32'd0);
        chk("t4_state", {31'd0, bus.o_state}, {31'd0, ST_UNLOCK});
        soft_rst   = 1'b1;
        bus.i_seed = 8'hA5;
        @(posedge clk);
        #1;
        soft_rst = 1'b0;
        chk("t4_dataA5", {24'd0, bus.o_data}, 32'hA5);
        exp_gen = 8'hA5;
        vstep("t4v", 1'b0, 1'b0, 1'b0, 32'd0);
        chk("t4_data4A", {24'd0, bus.o_data}, 32'h4A);

        // Test 5: lock, then soft_rst together with i_valid
        vstep("t5a", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t5b", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t5c", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t5d", 1'b0, 1'b1, 1'b1, 32'd0);
        soft_rst    = 1'b1;
        bus.i_seed  = 8'h3C;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        soft_rst    = 1'b0;
        bus.i_valid = 1'b0;
        chk("t5_lock",  {31'd0, bus.o_lock}, 32'd0);
        chk("t5_data",  {24'd0, bus.o_data}, 32'h3C);
        chk("t5_match", {31'd0, bus.o_match}, 32'd0);
        exp_gen = 8'h3C;

        // Test 6: error counter saturation
        vstep("t6a", 1'b0, 1'b0, 1'b0, 32'd0);
        vstep("t6b", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t6c", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t6d", 1'b0, 1'b1, 1'b0, 32'd0);
        vstep("t6e", 1'b0, 1'b1, 1'b1, 32'd0);
`ifdef PRBS_ERR_CNT_EN
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        #1;
        chk("t6_preload", {16'd0, bus.o_err_cnt}, 32'hFFFE);
        sat = 32'hFFFF;
`else
        sat = 32'd0;
`endif
        vstep("t6f", 1'b1, 1'b0, 1'b1, sat);
        vstep("t6g", 1'b0, 1'b1, 1'b1, sat);
        vstep("t6h", 1'b1, 1'b0, 1'b1, sat);
        vstep("t6i", 1'b0, 1'b1, 1'b1, sat);
        vstep("t6j", 1'b1, 1'b0, 1'b1, sat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
